// File: rtl/spectrum_frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spectrum_pkg
//  Purpose  : Shared types for the stereo spectrum frame sequencer: the
//             sequencer state encoding, channel constants and a helper that
//             identifies the watchdog-guarded wait states.
//  Revision : 1.0  initial release
// ============================================================================
package spectrum_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LOAD  = 4'd1,
        ST_W_IN  = 4'd2,
        ST_W_FFT = 4'd3,
        ST_SL    = 4'd4,
        ST_W_SL  = 4'd5,
        ST_SW    = 4'd6,
        ST_W_SW  = 4'd7,
        ST_ERR   = 4'd8
    } sequencer_state_t;

    localparam logic CH_R = 1'b0;
    localparam logic CH_L = 1'b1;

    // States in which the sequencer waits on a done strobe from a stage.
    function automatic logic is_wait_state(input sequencer_state_t s);
        return (s == ST_W_IN) || (s == ST_W_FFT) || (s == ST_W_SL) || (s == ST_W_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spectrum_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : spectrum_frame_sequencer_if
//  Purpose  : Control/status bundle between the frame sequencer and the
//             surrounding pipeline (loader, FFT, spectolizer, writer).
//  Modports : master - the sequencer (drives start pulses and status)
//             slave  - the pipeline/system side (drives ticks and strobes)
//  Revision : 1.0  initial release
// ============================================================================
interface spectrum_frame_sequencer_if #(
    parameter int BW_DROP = 8
) ();
    logic               enable;
    logic               frame_tick;
    logic               clear;
    logic               start_loader;
    logic               input_end;
    logic               fft_end;
    logic               start_sl;
    logic               end_sl;
    logic               start_sw;
    logic               end_sw;
    logic               channel;
    logic               lr_change;
    logic               busy;
    logic               frame_done;
    logic               timeout_err;
    logic [BW_DROP-1:0] drop_count;

    modport master (
        input  enable, frame_tick, clear, input_end, fft_end, end_sl, end_sw,
        output start_loader, start_sl, start_sw, channel, lr_change, busy,
               frame_done, timeout_err, drop_count
    );

    modport slave (
        output enable, frame_tick, clear, input_end, fft_end, end_sl, end_sw,
        input  start_loader, start_sl, start_sw, channel, lr_change, busy,
               frame_done, timeout_err, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/spectrum_frame_sequencer_stage_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : stage_watchdog
//  Purpose  : Per-state wait timer. Restarts whenever the observed state
//             changes, counts every cycle spent in a wait state and flags
//             expiry on the cycle the count reaches all-ones.
//  Ports    : clk_i, rst_i (async, active-high), state_i (current sequencer
//             state), expired_o (combinational expiry flag)
//  Revision : 1.0  initial release
// ============================================================================
module stage_watchdog
    import spectrum_pkg::*;
#(
    parameter int BW_TIMEOUT = 20
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire sequencer_state_t state_i,
    output logic                  expired_o
);

    sequencer_state_t        prev_q;
    logic [BW_TIMEOUT-1:0]   cnt_q;
    logic [BW_TIMEOUT-1:0]   w_cnt;
    logic [BW_TIMEOUT-1:0]   w_cnt_inc;
    logic                    w_wait;

    assign w_wait    = is_wait_state(state_i);
    // A state change restarts the count from zero in the entry cycle itself.
    assign w_cnt     = (state_i != prev_q) ? '0 : cnt_q;
    // The incremented value equals the number of cycles spent in this state.
    assign w_cnt_inc = w_cnt + {{(BW_TIMEOUT-1){1'b0}}, 1'b1};
    assign expired_o = w_wait && (w_cnt_inc == '1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= ST_IDLE;
            cnt_q  <= '0;
        end else begin
            prev_q <= state_i;
            cnt_q  <= w_wait ? w_cnt_inc : '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spectrum_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : spectrum_frame_sequencer
//  Purpose  : Frame controller for the stereo spectrum pipeline. Each frame
//             tick runs loader -> FFT -> spectolizer -> writer for channel R
//             and then channel L, with a watchdog on every wait, one-deep
//             tick queueing and a saturating dropped-tick counter.
//  Ports    : clk_i, rst_i (async, active-high), bus (master modport of
//             spectrum_frame_sequencer_if carrying ticks, strobes, start
//             pulses and status)
//  Revision : 1.0  initial release
// ============================================================================
module spectrum_frame_sequencer
    import spectrum_pkg::*;
#(
    parameter int BW_TIMEOUT = 20,
    parameter int BW_DROP    = 8
) (
    input  wire logic                   clk_i,
    input  wire logic                   rst_i,
    spectrum_frame_sequencer_if.master  bus
);

    sequencer_state_t    state_q;
    logic                pending_q;
    logic                channel_q;
    logic                start_loader_q;
    logic                start_sl_q;
    logic                start_sw_q;
    logic                lr_change_q;
    logic                busy_q;
    logic                frame_done_q;
    logic                timeout_err_q;
    logic [BW_DROP-1:0]  drop_count_q;

    logic                w_expired;
    logic                w_tick_blocked;
    logic                w_drop;

    stage_watchdog #(
        .BW_TIMEOUT (BW_TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .state_i   (state_q),
        .expired_o (w_expired)
    );

    // A tick that cannot start a frame right now is queued once; further
    // ticks while one is already queued are dropped.
    assign w_tick_blocked = bus.frame_tick && (busy_q || !bus.enable);
    assign w_drop         = w_tick_blocked && pending_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            pending_q      <= 1'b0;
            channel_q      <= CH_R;
            start_loader_q <= 1'b0;
            start_sl_q     <= 1'b0;
            start_sw_q     <= 1'b0;
            lr_change_q    <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            start_loader_q <= 1'b0;
            start_sl_q     <= 1'b0;
            start_sw_q     <= 1'b0;
            lr_change_q    <= 1'b0;
            frame_done_q   <= 1'b0;

            if (w_tick_blocked && !pending_q) begin
                pending_q <= 1'b1;
            end

            // Pulses are raised on the transition edge so that each one is
            // high exactly during the first cycle of its state.
            if (w_expired) begin
                state_q   <= ST_ERR;
                channel_q <= CH_R;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if ((bus.frame_tick || pending_q) && bus.enable) begin
                            state_q        <= ST_LOAD;
                            channel_q      <= CH_R;
                            pending_q      <= 1'b0;
                            start_loader_q <= 1'b1;
                            busy_q         <= 1'b1;
                        end
                    end
                    ST_LOAD:  state_q <= ST_W_IN;
                    ST_W_IN:  if (bus.input_end) state_q <= ST_W_FFT;
                    ST_W_FFT: begin
                        if (bus.fft_end) begin
                            state_q    <= ST_SL;
                            start_sl_q <= 1'b1;
                        end
                    end
                    ST_SL:    state_q <= ST_W_SL;
                    ST_W_SL: begin
                        if (bus.end_sl) begin
                            state_q    <= ST_SW;
                            start_sw_q <= 1'b1;
                        end
                    end
                    ST_SW:    state_q <= ST_W_SW;
                    ST_W_SW: begin
                        if (bus.end_sw) begin
                            if (channel_q == CH_R) begin
                                state_q        <= ST_LOAD;
                                channel_q      <= CH_L;
                                lr_change_q    <= 1'b1;
                                start_loader_q <= 1'b1;
                            end else begin
                                state_q      <= ST_IDLE;
                                frame_done_q <= 1'b1;
                                busy_q       <= 1'b0;
                            end
                        end
                    end
                    ST_ERR: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sticky status. A watchdog expiry takes precedence over a same-cycle
    // Clear; a Clear takes precedence over a same-cycle drop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timeout_err_q <= 1'b0;
            drop_count_q  <= '0;
        end else begin
            if (w_expired) begin
                timeout_err_q <= 1'b1;
            end else if (bus.clear) begin
                timeout_err_q <= 1'b0;
            end

            if (bus.clear) begin
                drop_count_q <= '0;
            end else if (w_drop && (drop_count_q != '1)) begin
                drop_count_q <= drop_count_q + {{(BW_DROP-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.start_loader = start_loader_q;
    assign bus.start_sl     = start_sl_q;
    assign bus.start_sw     = start_sw_q;
    assign bus.channel      = channel_q;
    assign bus.lr_change    = lr_change_q;
    assign bus.busy         = busy_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.timeout_err  = timeout_err_q;
    assign bus.drop_count   = drop_count_q;

endmodule
`default_nettype wire
